// File: rtl/ex_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative unsigned mul/div,
// registered EX/MEM output with hold and flush.
module ex_stage_mc #(
  parameter int XLEN = 32,
  parameter int NFWD = 3,
  parameter int CNTW = $clog2(XLEN)
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  input  logic [3:0]           in_op,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_regwrite,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_alusrc,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [5*NFWD-1:0]    fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic                 mem_hold,
  input  logic                 flush,
  output logic                 stall,
  output logic                 out_valid,
  output logic [4:0]           out_rd,
  output logic                 out_regwrite,
  output logic [XLEN-1:0]      out_res
);

  // state | meaning
  // IDLE  | accepting instructions; single-cycle ops complete here
  // BUSY  | one radix-2 mul/div step per cycle, XLEN steps
  // DONE  | multi-cycle result written to EX/MEM on the next edge
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [3:0]        mc_op;
  logic [4:0]        mc_rd;
  logic              mc_regwrite;
  logic [XLEN-1:0]   mc_b;
  logic [2*XLEN-1:0] acc;

  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   op_b;
  logic [CNTW-1:0]   shamt;
  logic [XLEN-1:0]   alu_res;
  logic              is_mc;
  logic              mc_is_div;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_tmp;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   mc_res;

  // Walk from the oldest source down so the lowest matching index wins.
  always_comb begin
    op_a    = in_rs1_data;
    rs2_val = in_rs2_data;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && in_rs1 != 5'd0 && fwd_rd[i*5 +: 5] == in_rs1)
        op_a = fwd_data[i*XLEN +: XLEN];
      if (fwd_valid[i] && in_rs2 != 5'd0 && fwd_rd[i*5 +: 5] == in_rs2)
        rs2_val = fwd_data[i*XLEN +: XLEN];
    end
    op_b = in_alusrc ? in_imm : rs2_val;
  end

  assign shamt = op_b[CNTW-1:0];
  assign is_mc = (in_op >= OP_MUL) && (in_op <= OP_REMU);

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_res = '0;
    endcase
  end

  // Shift-add multiply: acc = {partial high, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mc_b};
  assign mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

  // Restoring divide: acc = {remainder, quotient}. The top diff bit is the borrow,
  // since the partial remainder never reaches twice the divisor. A zero divisor
  // never borrows, giving an all-ones quotient and the dividend as remainder.
  assign div_tmp   = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = div_tmp - {1'b0, mc_b};
  assign div_next  = !div_diff[XLEN] ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                                     : {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  assign mc_is_div = (mc_op == OP_DIVU) || (mc_op == OP_REMU);

  always_comb begin
    mc_res = '0;
    case (mc_op)
      OP_MUL:   mc_res = acc[XLEN-1:0];
      OP_MULHU: mc_res = acc[2*XLEN-1:XLEN];
      OP_DIVU:  mc_res = acc[XLEN-1:0];
      OP_REMU:  mc_res = acc[2*XLEN-1:XLEN];
      default:  mc_res = '0;
    endcase
  end

  assign stall = Rst && ((state == IDLE && in_valid && is_mc) ||
                         (state == BUSY) ||
                         (mem_hold && in_valid));

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mc_op        <= '0;
      mc_rd        <= '0;
      mc_regwrite  <= 1'b0;
      mc_b         <= '0;
      acc          <= '0;
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_res      <= '0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_regwrite <= 1'b0;
    end else if (!mem_hold) begin
      case (state)
        IDLE: begin
          if (in_valid && is_mc) begin
            mc_op        <= in_op;
            mc_rd        <= in_rd;
            mc_regwrite  <= in_regwrite;
            mc_b         <= op_b;
            acc          <= {{XLEN{1'b0}}, op_a};
            cnt          <= '0;
            state        <= BUSY;
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
          end else if (in_valid) begin
            out_valid    <= 1'b1;
            out_rd       <= in_rd;
            out_regwrite <= in_regwrite;
            out_res      <= alu_res;
          end else begin
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
          end
        end
        BUSY: begin
          acc          <= mc_is_div ? div_next : mul_next;
          cnt          <= cnt + 1'b1;
          out_valid    <= 1'b0;
          out_regwrite <= 1'b0;
          if (cnt == CNTW'(XLEN - 1))
            state <= DONE;
        end
        DONE: begin
          out_valid    <= 1'b1;
          out_rd       <= mc_rd;
          out_regwrite <= mc_regwrite;
          out_res      <= mc_res;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed and randomised bench for ex_stage_mc with a result scoreboard.
module tb_ex_stage_mc;
  localparam int XLEN = 32;
  localparam int NFWD = 3;

  logic                 clk = 1'b0;
  logic                 Rst;
  logic                 in_valid;
  logic [3:0]           in_op;
  logic [4:0]           in_rs1, in_rs2, in_rd;
  logic                 in_regwrite;
  logic [XLEN-1:0]      in_rs1_data, in_rs2_data, in_imm;
  logic                 in_alusrc;
  logic [NFWD-1:0]      fwd_valid;
  logic [5*NFWD-1:0]    fwd_rd;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic                 mem_hold, flush;
  logic                 stall, out_valid, out_regwrite;
  logic [4:0]           out_rd;
  logic [XLEN-1:0]      out_res;

  always #5 clk = ~clk;

  ex_stage_mc #(.XLEN(XLEN), .NFWD(NFWD)) dut (
    .clk(clk), .Rst(Rst), .in_valid(in_valid), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alusrc(in_alusrc), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .mem_hold(mem_hold), .flush(flush), .stall(stall), .out_valid(out_valid),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .out_res(out_res)
  );

  int tests_run = 0;
  int failures  = 0;
  logic [37:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Drives one instruction from a negedge, holds it while stall is high, and
  // checks result, latency (edges to out_valid) and number of stalled cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_edges,
                        input int exp_stall, input int hold_at, input int hold_len);
    int n = 0;
    int st = 0;
    bit done = 0;
    logic [37:0] e;
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rs1_data = d1; in_rs2_data = d2; in_rd = rd; in_regwrite = 1'b1;
    sb.push_back({1'b1, rd, exp_res});
    while (!done && n < 200) begin
      mem_hold = (n >= hold_at) && (n < hold_at + hold_len);
      #1;
      if (stall) st++;
      @(posedge clk);
      n++;
      #1;
      if (out_valid) begin
        done = 1;
        in_valid = 1'b0;
        mem_hold = 1'b0;
        if (sb.size() == 0) check({tag, "_sb"}, 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          check(tag, {26'b0, out_regwrite, out_rd, out_res}, {26'b0, e});
        end
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_edges));
    check({tag, "_stall"}, 64'(st), 64'(exp_stall));
    if (!done) begin
      e = sb.pop_back();
      in_valid = 1'b0;
      mem_hold = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int seen;

    Rst = 1'b0; in_valid = 1'b1; in_op = 4'd10; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_rd = 5'd0; in_regwrite = 1'b0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_alusrc = 1'b0; fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
    mem_hold = 1'b0; flush = 1'b0;
    #3;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_outs", {25'b0, out_valid, out_regwrite, out_rd, out_res}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);

    run_op("add", 4'd0, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 32'd12, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("bubble", {out_valid, out_regwrite, out_res}, {2'b00, 32'd12});
    @(negedge clk);

    run_op("sub", 4'd1, 5'd1, 5'd2, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE, 1, 0, 0, 0);
    run_op("slt", 4'd8, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1, 1, 0, 0, 0);
    run_op("sltu", 4'd9, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, 1, 0, 0, 0);
    run_op("sra", 4'd7, 5'd1, 5'd2, 32'h8000_0000, 32'd4, 5'd6, 32'hF800_0000, 1, 0, 0, 0);
    run_op("srl", 4'd6, 5'd1, 5'd2, 32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000, 1, 0, 0, 0);
    run_op("sll_amt", 4'd5, 5'd1, 5'd2, 32'd1, 32'd36, 5'd6, 32'd16, 1, 0, 0, 0);
    run_op("reserved", 4'd14, 5'd1, 5'd2, 32'd9, 32'd9, 5'd7, 32'd0, 1, 0, 0, 0);

    fwd_valid = 3'b011;
    fwd_rd    = {5'd0, 5'd4, 5'd4};
    fwd_data  = {32'h0, 32'h1, 32'hAAAA_0000};
    run_op("fwd_prio", 4'd3, 5'd4, 5'd5, 32'h5555, 32'd0, 5'd8, 32'hAAAA_0000, 1, 0, 0, 0);
    fwd_rd    = {5'd0, 5'd0, 5'd0};
    run_op("fwd_x0", 4'd3, 5'd0, 5'd5, 32'h1234, 32'd0, 5'd8, 32'h1234, 1, 0, 0, 0);
    fwd_valid = 3'b010;
    fwd_rd    = {5'd0, 5'd4, 5'd4};
    run_op("fwd_b", 4'd0, 5'd1, 5'd4, 32'd10, 32'd500, 5'd8, 32'd11, 1, 0, 0, 0);
    fwd_valid = 3'b011;
    in_alusrc = 1'b1; in_imm = 32'd100;
    run_op("fwd_imm", 4'd0, 5'd1, 5'd4, 32'd10, 32'd500, 5'd8, 32'd110, 1, 0, 0, 0);
    in_alusrc = 1'b0; in_imm = '0; fwd_valid = '0; fwd_rd = '0; fwd_data = '0;

    run_op("mul", 4'd10, 5'd1, 5'd2, 32'h1_0000, 32'h1_0000, 5'd10, 32'h0, 34, 33, 0, 0);
    run_op("mulhu", 4'd11, 5'd1, 5'd2, 32'h1_0000, 32'h1_0000, 5'd11, 32'h1, 34, 33, 0, 0);
    run_op("divu", 4'd12, 5'd1, 5'd2, 32'd100, 32'd7, 5'd12, 32'd14, 34, 33, 0, 0);
    run_op("remu", 4'd13, 5'd1, 5'd2, 32'd100, 32'd7, 5'd13, 32'd2, 34, 33, 0, 0);
    run_op("divu0", 4'd12, 5'd1, 5'd2, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 34, 33, 0, 0);
    run_op("remu0", 4'd13, 5'd1, 5'd2, 32'd5, 32'd0, 5'd13, 32'd5, 34, 33, 0, 0);
    run_op("mul_hold", 4'd10, 5'd1, 5'd2, 32'd3, 32'd5, 5'd14, 32'd15, 37, 36, 10, 3);

    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 9));
      a = $urandom; b = $urandom;
      run_op("rand_alu", op, 5'd1, 5'd2, a, b, 5'd15, model(op, a, b), 1, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      op = 4'($urandom_range(10, 13));
      a = $urandom; b = 32'($urandom_range(1, 100000));
      run_op("rand_mc", op, 5'd1, 5'd2, a, b, 5'd16, model(op, a, b), 34, 33, 0, 0);
    end

    // flush mid-BUSY
    in_valid = 1'b1; in_op = 4'd12; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_rs1_data = 32'd1000; in_rs2_data = 32'd3; in_rd = 5'd9;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("flush_outs", {out_valid, out_regwrite}, 2'b00);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", 64'(stall), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    @(negedge clk);
    run_op("post_flush_add", 4'd0, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 32'd12, 1, 0, 0, 0);

    // asynchronous reset mid-BUSY
    in_valid = 1'b1; in_op = 4'd10; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_rs1_data = 32'd6; in_rs2_data = 32'd7; in_rd = 5'd9;
    repeat (10) @(posedge clk);
    #2 Rst = 1'b0;
    #1;
    check("areset_outs", {25'b0, out_valid, out_regwrite, out_rd, out_res}, 64'd0);
    check("areset_stall", 64'(stall), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    run_op("post_reset_add", 4'd0, 5'd1, 5'd2, 32'd20, 32'd22, 5'd3, 32'd42, 1, 0, 0, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
